// File: rtl/mbox_resp.sv
// mbox_resp: behavioural MBOX responder terminating the EBOX memory-request interface.
// Define MBOX_RESP_PARITY_EN to store an odd-parity bit per word and flag read-parity errors.
module mbox_resp #(
    parameter int ADR_BITS = 10,
    parameter int LATENCY  = 3
) (
    input  logic         clk,
    input  logic         CROBAR,
    input  logic         EBOX_REQ,
    input  logic         eboxRead,
    input  logic         eboxWrite,
    input  logic [13:35] EBOX_VMA,
    input  logic [0:35]  cacheDataWrite,
    input  logic         errClr,
    input  logic         parInject,
    output logic         cshEBOXT0,
    output logic         mboxRespIn,
    output logic [0:35]  cacheDataRead,
    output logic         mboxBusy,
    output logic         nxmErr,
    output logic         mbParErr
);
    localparam int DEPTH = 2 ** ADR_BITS;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_PAUSE} state_t;

    state_t              state, state_nx;
    logic [3:0]          cnt;
    logic [13:35]        lat_adr;
    logic [22:0]         adr_num;
    logic                lat_rd, lat_wr;
    logic [0:35]         lat_data;
    logic                accept, resp_entry, nxm, store_wr;
    logic [ADR_BITS-1:0] idx;
    logic [0:35]         mem [DEPTH];

    assign adr_num  = lat_adr;
    assign nxm      = (adr_num >> ADR_BITS) != '0;
    assign idx      = adr_num[ADR_BITS-1:0];
    assign store_wr = resp_entry && lat_wr && !lat_rd && !nxm;

    // Every accept passes through WAIT with the counter running LATENCY-1 down to 0,
    // so the strobe lands LATENCY cycles after the accept edge for every legal LATENCY.
    always_comb begin
        state_nx   = state;
        accept     = 1'b0;
        resp_entry = 1'b0;
        case (state)
            S_IDLE: begin
                if (EBOX_REQ) begin
                    accept   = 1'b1;
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt == '0) begin
                    resp_entry = 1'b1;
                    state_nx   = S_RESP;
                end
            end
            S_RESP: begin
                state_nx = (lat_rd && lat_wr && !nxm) ? S_PAUSE : S_IDLE;
            end
            S_PAUSE: begin
                if (EBOX_REQ) begin
                    accept   = 1'b1;
                    state_nx = S_WAIT;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign mboxRespIn = (state == S_RESP);
    assign mboxBusy   = (state != S_IDLE);

    always_ff @(posedge clk or posedge CROBAR) begin
        if (CROBAR) begin
            state     <= S_IDLE;
            cnt       <= '0;
            cshEBOXT0 <= 1'b0;
            lat_adr   <= '0;
            lat_rd    <= 1'b0;
            lat_wr    <= 1'b0;
            lat_data  <= '0;
        end else begin
            state     <= state_nx;
            cshEBOXT0 <= accept;
            if (accept) begin
                cnt      <= 4'(LATENCY - 1);
                lat_data <= cacheDataWrite;
                if (state == S_PAUSE) begin
                    // PSE write phase: address stays locked, eboxRead is ignored.
                    lat_rd <= 1'b0;
                    lat_wr <= 1'b1;
                end else begin
                    lat_adr <= EBOX_VMA;
                    lat_rd  <= eboxRead;
                    lat_wr  <= eboxWrite;
                end
            end else if (state == S_WAIT && cnt != '0) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (store_wr) begin
            mem[idx] <= lat_data;
        end
    end

    always_ff @(posedge clk or posedge CROBAR) begin
        if (CROBAR) begin
            cacheDataRead <= '0;
            nxmErr        <= 1'b0;
        end else begin
            if (resp_entry && lat_rd) begin
                cacheDataRead <= nxm ? '0 : mem[idx];
            end
            if (resp_entry && nxm) begin
                nxmErr <= 1'b1;
            end else if (errClr) begin
                nxmErr <= 1'b0;
            end
        end
    end

`ifdef MBOX_RESP_PARITY_EN
    logic lat_inj;
    logic mem_par [DEPTH];

    always_ff @(posedge clk or posedge CROBAR) begin
        if (CROBAR) begin
            lat_inj <= 1'b0;
        end else if (accept) begin
            lat_inj <= parInject;
        end
    end

    always_ff @(posedge clk) begin
        if (store_wr) begin
            mem_par[idx] <= ~(^lat_data) ^ lat_inj;
        end
    end

    always_ff @(posedge clk or posedge CROBAR) begin
        if (CROBAR) begin
            mbParErr <= 1'b0;
        end else if (resp_entry && lat_rd && !nxm && !(^{mem_par[idx], mem[idx]})) begin
            mbParErr <= 1'b1;
        end else if (errClr) begin
            mbParErr <= 1'b0;
        end
    end
`else
    logic par_unused;
    assign par_unused = parInject;
    assign mbParErr   = 1'b0;
`endif

endmodule
